sisa_wb_stage: RTL

//  MEM/WB pipeline register and writeback stage of the SISA core, directly downstream of the memory stage.

---
 rtl/sisa_pkg.sv | 19 +
 rtl/sisa_sat_counter.sv | 33 +++
 rtl/sisa_wb_stage.sv | 123 ++++++++++++
 3 files changed

// File: rtl/sisa_pkg.sv
// rtl/sisa_pkg.sv - shared types and constants for the SISA writeback stage
package sisa_pkg;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_LOAD = 2'd1,
    WB_PC4  = 2'd2
  } wb_sel_e;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } wb_state_e;

  localparam logic [31:0] HALT_OPCODE  = 32'h0000_0001;
  localparam logic [31:0] INSTR_BUBBLE = 32'h0000_0000;

endpackage

// File: rtl/sisa_sat_counter.sv
// rtl/sisa_sat_counter.sv - saturating up-counter with clear and enable
module sisa_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/sisa_wb_stage.sv
// rtl/sisa_wb_stage.sv - MEM/WB register, writeback mux and halt drain FSM
// Optional retire counter and per-retire trace enabled by SISA_WB_TRACE_EN.
module sisa_wb_stage #(
  parameter int XLEN         = 32,
  parameter int NREGS        = 16,
  parameter int RW           = $clog2(NREGS),
  parameter int DRAIN_CYCLES = 4,
  parameter int CNT_W        = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            mem_valid,
  output logic            mem_ready,
  input  logic [31:0]     mem_instr,
  input  logic            mem_we,
  input  logic [RW-1:0]   mem_rd,
  input  logic [1:0]      mem_sel,
  input  logic [XLEN-1:0] mem_alu,
  input  logic [XLEN-1:0] mem_load,
  input  logic [XLEN-1:0] mem_pc4,
  output logic            rf_we,
  output logic [RW-1:0]   rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic [31:0]     instr_wb,
  output logic            halted
`ifdef SISA_WB_TRACE_EN
  ,
  output logic [CNT_W-1:0] retire_cnt
`endif
);

  import sisa_pkg::*;

  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

  wb_state_e       state_q, state_d;
  logic            mem_ready_q, mem_ready_d;
  logic            halted_q, halted_d;
  logic            rf_we_q, rf_we_d;
  logic [RW-1:0]   rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
  logic [31:0]     instr_wb_q, instr_wb_d;
  logic            transfer, is_halt;
  logic [DW-1:0]   drain_cnt;

  always_comb begin
    transfer = mem_valid & mem_ready_q;
    is_halt  = transfer & (mem_instr == HALT_OPCODE);

    state_d = state_q;
    case (state_q)
      RUN:     if (is_halt) state_d = DRAIN;
      DRAIN:   if (drain_cnt == DRAIN_LAST) state_d = HALTED;
      HALTED:  state_d = HALTED;
      default: state_d = RUN;
    endcase

    mem_ready_d = (state_d == RUN);
    // halted trails entry into HALTED by one edge so it rises DRAIN_CYCLES+1 edges after the halt.
    halted_d    = (state_q == HALTED);

    rf_we_d    = transfer & mem_we & (mem_rd != '0) & ~is_halt;
    rf_waddr_d = mem_rd;
    case (mem_sel)
      WB_ALU:  rf_wdata_d = mem_alu;
      WB_LOAD: rf_wdata_d = mem_load;
      WB_PC4:  rf_wdata_d = mem_pc4;
      default: rf_wdata_d = '0;
    endcase
    instr_wb_d = transfer ? mem_instr : INSTR_BUBBLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      mem_ready_q <= 1'b1;
      halted_q    <= 1'b0;
      rf_we_q     <= 1'b0;
      rf_waddr_q  <= '0;
      rf_wdata_q  <= '0;
      instr_wb_q  <= INSTR_BUBBLE;
    end else begin
      state_q     <= state_d;
      mem_ready_q <= mem_ready_d;
      halted_q    <= halted_d;
      rf_we_q     <= rf_we_d;
      rf_waddr_q  <= rf_waddr_d;
      rf_wdata_q  <= rf_wdata_d;
      instr_wb_q  <= instr_wb_d;
    end
  end

  sisa_sat_counter #(.W(DW)) u_drain_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (is_halt),
    .en    (state_q == DRAIN),
    .cnt   (drain_cnt)
  );

`ifdef SISA_WB_TRACE_EN
  sisa_sat_counter #(.W(CNT_W)) u_retire_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (1'b0),
    .en    (transfer),
    .cnt   (retire_cnt)
  );

  always_ff @(posedge clk) begin
    if (!reset && transfer) $display("WB pc4=%h instr=%h", mem_pc4, mem_instr);
  end
`endif

  assign mem_ready = mem_ready_q;
  assign halted    = halted_q;
  assign rf_we     = rf_we_q;
  assign rf_waddr  = rf_waddr_q;
  assign rf_wdata  = rf_wdata_q;
  assign instr_wb  = instr_wb_q;

endmodule
